// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an 8x8 ROM sprite (draw/erase) or the whole screen
// (clear) and streams one registered pixel write per cycle to a VGA adapter.
// Optional build macro: SPRITE_TRANSPARENT_EN -- when defined, zero bits of
// a drawn sprite are skipped instead of being painted black.
module sprite_blitter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_x,
    input  logic [6:0] cmd_y,
    input  logic [1:0] cmd_sprite,
    input  logic [2:0] color_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out,
    output logic       writeEn,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR, S_DONE} state_t;

    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam logic [8:0] X_LIMIT    = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT    = 8'(SCREEN_H);
    localparam logic [7:0] CLR_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] CLR_Y_LAST = 7'(SCREEN_H - 1);

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] base_x_q, base_x_d;
    logic [6:0] base_y_q, base_y_d;
    logic [1:0] sprite_q, sprite_d;
    logic [2:0] color_q, color_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic       last_q, last_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] color_out_q, color_out_d;
    logic       we_q, we_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;

    logic       starting;
    logic [1:0] cur_op;
    logic [7:0] cur_x;
    logic [6:0] cur_y;
    logic [1:0] cur_sprite;
    logic [2:0] cur_color;
    logic [7:0] cur_cx;
    logic [6:0] cur_cy;
    logic [8:0] tgt_x;
    logic [7:0] tgt_y;
    logic       clipped;
    logic       rom_on;
    logic       scan_clear;
    logic       scan_last;
    logic [7:0] next_cx;
    logic [6:0] next_cy;
    logic       pix_we;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_color;

    // Fixed sprite ROM: each sprite is a closed-form pattern over (cx, cy).
    function automatic logic rom_bit(input logic [1:0] sprite,
                                     input logic [2:0] cx,
                                     input logic [2:0] cy);
        case (sprite)
            2'd0:    rom_bit = 1'b1;
            2'd1:    rom_bit = (cx == 3'd0) || (cx == 3'd7) || (cy == 3'd0) || (cy == 3'd7);
            2'd2:    rom_bit = cx[0] ^ cy[0];
            default: rom_bit = (cx == cy);
        endcase
    endfunction

    // Pixel generator: in IDLE it previews pixel 0 from the live command so the
    // first write lands one cycle after accept; otherwise it uses the latched command.
    always_comb begin
        starting   = (state_q == S_IDLE);
        cur_op     = starting ? cmd_op     : op_q;
        cur_x      = starting ? cmd_x      : base_x_q;
        cur_y      = starting ? cmd_y      : base_y_q;
        cur_sprite = starting ? cmd_sprite : sprite_q;
        cur_color  = starting ? color_in   : color_q;
        cur_cx     = starting ? 8'd0       : cx_q;
        cur_cy     = starting ? 7'd0       : cy_q;
        scan_clear = (cur_op == OP_CLEAR);

        tgt_x   = {1'b0, cur_x} + {6'b0, cur_cx[2:0]};
        tgt_y   = {1'b0, cur_y} + {5'b0, cur_cy[2:0]};
        clipped = (tgt_x >= X_LIMIT) || (tgt_y >= Y_LIMIT);
        rom_on  = rom_bit(cur_sprite, cur_cx[2:0], cur_cy[2:0]);

        if (scan_clear) begin
            pix_x     = cur_cx;
            pix_y     = cur_cy;
            pix_color = cur_color;
            pix_we    = 1'b1;
            scan_last = (cur_cx == CLR_X_LAST) && (cur_cy == CLR_Y_LAST);
            next_cx   = (cur_cx == CLR_X_LAST) ? 8'd0 : cur_cx + 8'd1;
            next_cy   = (cur_cx == CLR_X_LAST) ? cur_cy + 7'd1 : cur_cy;
        end else begin
            pix_x     = tgt_x[7:0];
            pix_y     = tgt_y[6:0];
            pix_color = (cur_op == OP_DRAW && rom_on) ? cur_color : 3'b000;
            pix_we    = !clipped;
`ifdef SPRITE_TRANSPARENT_EN
            if (cur_op == OP_DRAW && !rom_on) begin
                pix_we = 1'b0;
            end
`endif
            scan_last = (cur_cx[2:0] == 3'd7) && (cur_cy[2:0] == 3'd7);
            next_cx   = (cur_cx[2:0] == 3'd7) ? 8'd0 : cur_cx + 8'd1;
            next_cy   = (cur_cx[2:0] == 3'd7) ? cur_cy + 7'd1 : cur_cy;
        end
    end

    // Next-state and next-output logic for the command FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        sprite_d    = sprite_q;
        color_d     = color_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        last_d      = last_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        color_out_d = color_out_q;
        we_d        = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d     = cmd_op;
                    base_x_d = cmd_x;
                    base_y_d = cmd_y;
                    sprite_d = cmd_sprite;
                    color_d  = color_in;
                    if (cmd_op == OP_NOP) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        x_out_d     = pix_x;
                        y_out_d     = pix_y;
                        color_out_d = pix_color;
                        we_d        = pix_we;
                        cx_d        = next_cx;
                        cy_d        = next_cy;
                        last_d      = scan_last;
                        state_d     = scan_clear ? S_CLEAR : S_DRAW;
                    end
                end
            end
            S_DRAW, S_CLEAR: begin
                if (last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    x_out_d     = pix_x;
                    y_out_d     = pix_y;
                    color_out_d = pix_color;
                    we_d        = pix_we;
                    cx_d        = next_cx;
                    cy_d        = next_cy;
                    last_d      = scan_last;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            base_x_q    <= 8'd0;
            base_y_q    <= 7'd0;
            sprite_q    <= 2'd0;
            color_q     <= 3'd0;
            cx_q        <= 8'd0;
            cy_q        <= 7'd0;
            last_q      <= 1'b0;
            x_out_q     <= 8'd0;
            y_out_q     <= 7'd0;
            color_out_q <= 3'd0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            sprite_q    <= sprite_d;
            color_q     <= color_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            last_q      <= last_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            color_out_q <= color_out_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign color_out = color_out_q;
    assign writeEn   = we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible pixel rows.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_op  input  2  00 draw sprite, 01 erase sprite, 10 clear screen, 11 no-op.
REQ-008 SHALL have ports cmd_x  input  8  and cmd_y  input  7  sprite top-left corner.
REQ-009 SHALL have port cmd_sprite  input  2  sprite index into the internal ROM.
REQ-010 SHALL have port color_in  input  3  draw or clear colour.
REQ-011 SHALL have ports x_out  output  8, y_out  output  7, color_out  output  3 and writeEn  output  1  pixel write to the VGA adapter.
REQ-012 SHALL have ports busy  output  1  command in progress, and done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, DRAW, CLEAR and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-014 Accept SHALL occur in cycle A when cmd_valid and cmd_ready are both 1; cmd_op, cmd_x, cmd_y, cmd_sprite and color_in SHALL be latched at A; inputs in other cycles SHALL be ignored.
REQ-015 Transitions SHALL be: op 00/01 IDLE->DRAW; op 10 IDLE->CLEAR; op 11 IDLE->DONE; DRAW/CLEAR->DONE after the last pixel; DONE->IDLE after one cycle.
REQ-016 All pixel outputs SHALL be registered; pixel k of a command SHALL appear in cycle A+1+k, one pixel per cycle, with no stalls.
REQ-017 DRAW SHALL scan an 8x8 block row-major (column inner), 64 cycles; the pixel at offset (cx,cy) SHALL target (cmd_x+cx, cmd_y+cy), with the sums computed at 9 bits for x and 8 bits for y.
REQ-018 ROM contents SHALL be fixed, with bit(cx,cy) defined per sprite: 0 solid (always 1); 1 border (cx or cy equal to 0 or 7); 2 checker ((cx^cy) lsb equal to 1); 3 diagonal (cx==cy).
REQ-019 For op 00, a ROM bit of 1 SHALL write color_in.
REQ-020 For op 01, every pixel SHALL write 3'b000, regardless of ROM contents.
REQ-021 Clipping: a target with x>=SCREEN_W or y>=SCREEN_H SHALL hold writeEn at 0 for that cycle; scan timing SHALL be unchanged, and x_out/y_out SHALL carry the truncated low bits.
REQ-022 CLEAR SHALL write color_in to every pixel, x 0..SCREEN_W-1 inner and y 0..SCREEN_H-1 outer, for 19200 cycles at the defaults.
REQ-023 In cycles where writeEn is 0, x_out, y_out and color_out SHALL hold don't-care values that are not checked.
REQ-024 done SHALL be 1 in cycle A+1+P, where P is the pixel count (64, 19200 or 0); cmd_ready SHALL be 1 again in cycle A+2+P.
REQ-025 busy SHALL be 1 in DRAW, CLEAR and DONE, and 0 in IDLE.
REQ-026 A cmd_valid held high through DONE SHALL be accepted in the first IDLE cycle, giving back-to-back commands with one idle cycle between them.

Reset
REQ-027 When reset is 1 at a rising edge, the block SHALL enter IDLE and drive writeEn=0, x_out=0, y_out=0, color_out=0, done=0 and busy=0.
REQ-028 Reset SHALL take priority over a simultaneous accept.
REQ-029 Reset during DRAW or CLEAR SHALL abort the command with no further writes and no done pulse.
REQ-030 cmd_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-031 With macro SPRITE_TRANSPARENT_EN defined, op 00 pixels with ROM bit 0 SHALL have writeEn=0 (transparent).
REQ-032 Without SPRITE_TRANSPARENT_EN, op 00 pixels with ROM bit 0 SHALL be written with 3'b000, subject to clipping.
REQ-033 Op 01, op 10 and all timing SHALL be identical in both builds.

Verification
REQ-034 Bench SHALL drive op 00, sprite 0, (10,20), colour 101 -> 64 writes to (10..17, 20..27), all 101, first write at A+1, done at A+65.
REQ-035 Bench SHALL drive op 00, sprite 3, (0,0), colour 010 with SPRITE_TRANSPARENT_EN defined -> exactly 8 writes at (i,i) for i=0..7; without the macro -> 64 writes, 8 of them 010 and 56 of them 000.
REQ-036 Bench SHALL drive op 01 at (156,116) -> only the 16 pixels with x 156..159 and y 116..119 are written, all 000; done at A+65.
REQ-037 Bench SHALL drive op 10, colour 011 -> 19200 writes, the first at (0,0) and the last at (159,119); done at A+19201; cmd_ready is 1 at A+19202.
REQ-038 Bench SHALL assert reset at pixel 30 of a draw -> writeEn is 0 from the next cycle, no done pulse, cmd_ready is 1 after release, and the next command runs normally.
REQ-039 Bench SHALL hold cmd_valid high while busy and then issue an op 11 -> the held command is accepted at the first IDLE cycle; op 11 produces done at A+1 with no writes.
